// File: rtl/cnn_window_sequencer_if.sv
// -----------------------------------------------------------------------------
// cnn_window_sequencer_if
// Bundles the signals that connect cnn_window_sequencer to the rest of the
// system (frame control, pixel RAM, simpleCNN core).
//
// Signals (direction as seen by the sequencer, i.e. the master modport):
//   IMG_START  in   frame request
//   PIX_ADDR   out  pixel RAM read address
//   PIX_DATA   in   pixel RAM read data, valid one cycle after PIX_ADDR
//   IMGIN      out  packed window, byte (r*WIN+c) = pixel(X+r, Y+c)
//   X, Y       out  window top row / left column
//   START      out  one-cycle pulse to the CNN core
//   DONE       in   CNN core completion
//   WIN_CNT    out  windows completed in the current frame
//   BUSY       out  high whenever the sequencer is not idle
//   FRAME_DONE out  one-cycle pulse after the last window
// The slave modport is the environment's view (RAM, core, frame control).
// -----------------------------------------------------------------------------
interface cnn_window_sequencer_if #(
   parameter int IMG_W = 28,
   parameter int WIN   = 5,
   parameter int PIX_W = 8
);
   localparam int NPOS = IMG_W - WIN + 1;
   localparam int NPIX = WIN * WIN;
   localparam int NWIN = NPOS * NPOS;
   localparam int AW   = $clog2(IMG_W * IMG_W);
   localparam int PW   = $clog2(NPOS);
   localparam int CW   = $clog2(NWIN + 1);

   logic                    IMG_START;
   logic [AW-1:0]           PIX_ADDR;
   logic [PIX_W-1:0]        PIX_DATA;
   logic [NPIX*PIX_W-1:0]   IMGIN;
   logic [PW-1:0]           X;
   logic [PW-1:0]           Y;
   logic                    START;
   logic                    DONE;
   logic [CW-1:0]           WIN_CNT;
   logic                    BUSY;
   logic                    FRAME_DONE;

   modport master (
      input  IMG_START, PIX_DATA, DONE,
      output PIX_ADDR, IMGIN, X, Y, START, WIN_CNT, BUSY, FRAME_DONE
   );

   modport slave (
      output IMG_START, PIX_DATA, DONE,
      input  PIX_ADDR, IMGIN, X, Y, START, WIN_CNT, BUSY, FRAME_DONE
   );
endinterface

// File: rtl/cnn_window_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_window_sequencer
// Frame-level controller for the simpleCNN core. On a frame request it slides
// a WIN x WIN window over an IMG_W x IMG_W image held in a synchronous pixel
// RAM (one-cycle read latency). For every window position it fetches the
// WIN*WIN pixels into the packed IMGIN bus, pulses START for one cycle and
// waits for a rising edge of DONE, then advances in raster order (Y fastest).
//
// Ports:
//   CLK   in  clock, rising edge
//   nRST  in  asynchronous reset, active-low
//   bus   cnn_window_sequencer_if.master (IMG_START, PIX_ADDR, PIX_DATA,
//         IMGIN, X, Y, START, DONE, WIN_CNT, BUSY, FRAME_DONE)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module cnn_window_sequencer #(
   parameter int IMG_W = 28,
   parameter int WIN   = 5,
   parameter int PIX_W = 8
) (
   input  logic                   CLK,
   input  logic                   nRST,
   cnn_window_sequencer_if.master bus
);
   localparam int NPOS = IMG_W - WIN + 1;
   localparam int NPIX = WIN * WIN;
   localparam int NWIN = NPOS * NPOS;
   localparam int AW   = $clog2(IMG_W * IMG_W);
   localparam int PW   = $clog2(NPOS);
   localparam int FW   = $clog2(NPIX + 1);
   localparam int CW   = $clog2(NWIN + 1);

   localparam logic [PW-1:0] LAST_POS  = PW'(NPOS - 1);
   localparam logic [FW-1:0] LAST_F    = FW'(NPIX);
   localparam logic [FW-1:0] LAST_ADDR = FW'(NPIX - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_ADVANCE,
      S_FIN
   } state_t;

   state_t           state_q, state_d;
   logic [FW-1:0]    f_q, f_d;
   logic [PW-1:0]    x_q, x_d;
   logic [PW-1:0]    y_q, y_d;
   logic [CW-1:0]    win_cnt_q, win_cnt_d;
   logic [AW-1:0]    pix_addr_q, pix_addr_d;
   logic             start_q, start_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic             done_q;
   logic             done_rise;
   logic [NPIX*PIX_W-1:0] imgin_w;

   // Address of window pixel f for the window whose corner is (x, y).
   // f/WIN and f%WIN are divisions by a constant on a 5-bit value.
   function automatic logic [AW-1:0] win_addr(input logic [PW-1:0] x,
                                              input logic [PW-1:0] y,
                                              input logic [FW-1:0] f);
      logic [FW-1:0] r;
      logic [FW-1:0] c;
      r = f / FW'(WIN);
      c = f % FW'(WIN);
      return (AW'(x) + AW'(r)) * AW'(IMG_W) + AW'(y) + AW'(c);
   endfunction

   // A DONE level carried over from an earlier window must not count, so
   // only a 0->1 transition observed while waiting advances the sequencer.
   assign done_rise = bus.DONE & ~done_q;

   // -------------------------------------------------------------------------
   // Next-state and datapath control
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      f_d        = f_q;
      x_d        = x_q;
      y_d        = y_q;
      win_cnt_d  = win_cnt_q;
      pix_addr_d = pix_addr_q;

      case (state_q)
         S_IDLE: begin
            if (bus.IMG_START) begin
               x_d        = '0;
               y_d        = '0;
               win_cnt_d  = '0;
               f_d        = '0;
               pix_addr_d = win_addr('0, '0, '0);
               state_d    = S_FETCH;
            end
         end

         // PIX_ADDR is loaded one step ahead so that while the counter
         // reads f the RAM sees the address of pixel f; its data arrives
         // during step f+1 and is captured into byte f there.
         S_FETCH: begin
            if (f_q == LAST_F) begin
               state_d = S_ISSUE;
            end else begin
               f_d = f_q + FW'(1);
               if (f_q < LAST_ADDR) begin
                  pix_addr_d = win_addr(x_q, y_q, f_q + FW'(1));
               end
            end
         end

         S_ISSUE: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (done_rise) begin
               state_d = S_ADVANCE;
            end
         end

         S_ADVANCE: begin
            win_cnt_d = win_cnt_q + CW'(1);
            if (y_q < LAST_POS) begin
               y_d        = y_q + PW'(1);
               f_d        = '0;
               pix_addr_d = win_addr(x_q, y_q + PW'(1), '0);
               state_d    = S_FETCH;
            end else if (x_q < LAST_POS) begin
               y_d        = '0;
               x_d        = x_q + PW'(1);
               f_d        = '0;
               pix_addr_d = win_addr(x_q + PW'(1), '0, '0);
               state_d    = S_FETCH;
            end else begin
               state_d = S_FIN;
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output flags are decoded from the next state so that the registered
   // versions line up exactly with the state they describe.
   always_comb begin
      start_d      = (state_d == S_ISSUE);
      busy_d       = (state_d != S_IDLE);
      frame_done_d = (state_d == S_FIN);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= S_IDLE;
         f_q          <= '0;
         x_q          <= '0;
         y_q          <= '0;
         win_cnt_q    <= '0;
         pix_addr_q   <= '0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         f_q          <= f_d;
         x_q          <= x_d;
         y_q          <= y_d;
         win_cnt_q    <= win_cnt_d;
         pix_addr_q   <= pix_addr_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         done_q       <= bus.DONE;
      end
   end

   // -------------------------------------------------------------------------
   // Window byte registers: byte gi captures PIX_DATA on fetch step gi+1.
   // Bytes not yet rewritten keep the previous window's pixel.
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NPIX; gi++) begin : g_byte
         logic [PIX_W-1:0] byte_q, byte_d;

         always_comb begin
            byte_d = byte_q;
            if ((state_q == S_FETCH) && (f_q == FW'(gi + 1))) begin
               byte_d = bus.PIX_DATA;
            end
         end

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               byte_q <= '0;
            end else begin
               byte_q <= byte_d;
            end
         end

         assign imgin_w[gi*PIX_W +: PIX_W] = byte_q;
      end
   endgenerate

   assign bus.PIX_ADDR   = pix_addr_q;
   assign bus.IMGIN      = imgin_w;
   assign bus.X          = x_q;
   assign bus.Y          = y_q;
   assign bus.START      = start_q;
   assign bus.WIN_CNT    = win_cnt_q;
   assign bus.BUSY       = busy_q;
   assign bus.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_cnn_window_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cnn_window_sequencer
// Scoreboard bench: when a frame is requested the full list of expected
// windows (position, packed pixels, completed-window count) is computed from
// the RAM contents and queued; a monitor pops one entry per START pulse.
// A RAM model (1-cycle latency) and a CNN core model (DONE a fixed or random
// number of cycles after START) form the environment.
// -----------------------------------------------------------------------------
module tb_cnn_window_sequencer;
   localparam int IMG_W = 28;
   localparam int WIN   = 5;
   localparam int PIX_W = 8;
   localparam int NPOS  = IMG_W - WIN + 1;
   localparam int NWIN  = NPOS * NPOS;
   localparam int NPIX  = WIN * WIN;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   cnn_window_sequencer_if #(.IMG_W(IMG_W), .WIN(WIN), .PIX_W(PIX_W)) bus ();

   cnn_window_sequencer #(.IMG_W(IMG_W), .WIN(WIN), .PIX_W(PIX_W)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // ---------------- pixel RAM model ----------------
   logic [7:0] mem [0:IMG_W*IMG_W-1];
   logic [7:0] pix_data = 8'h00;
   always @(posedge CLK) pix_data <= mem[bus.PIX_ADDR];
   assign bus.PIX_DATA = pix_data;

   // ---------------- CNN core model ----------------
   logic core_auto  = 1'b1;
   logic done_man   = 1'b0;
   logic done_auto  = 1'b0;
   logic rand_delay = 1'b0;
   int   cd         = 0;
   // cd is loaded with (delay-1); DONE appears 'delay' cycles after START.
   always @(posedge CLK) begin
      done_auto <= 1'b0;
      if (bus.START) begin
         cd <= rand_delay ? int'($urandom_range(5, 1)) : 2;
      end else if (cd != 0) begin
         cd <= cd - 1;
         if (cd == 1) done_auto <= 1'b1;
      end
   end
   assign bus.DONE = core_auto ? done_auto : done_man;

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      int           idx;
      int           x;
      int           y;
      logic [199:0] img;
   } win_t;

   win_t exp_q[$];
   logic directed = 1'b0;

   function automatic logic [199:0] ref_window(input int x, input int y);
      logic [199:0] w;
      w = '0;
      for (int r = 0; r < WIN; r++)
         for (int c = 0; c < WIN; c++)
            w[(r*WIN + c)*8 +: 8] = mem[(x + r)*IMG_W + y + c];
      return w;
   endfunction

   task automatic push_frame();
      win_t e;
      exp_q.delete();
      for (int x = 0; x < NPOS; x++)
         for (int y = 0; y < NPOS; y++) begin
            e.idx = x*NPOS + y;
            e.x   = x;
            e.y   = y;
            e.img = ref_window(x, y);
            exp_q.push_back(e);
         end
   endtask

   function automatic logic [7:0] byte_of(input logic [199:0] img, input int k);
      return img[k*8 +: 8];
   endfunction

   // Hand-computed values for the identity image mem[a] = a[7:0].
   task automatic check_directed(input int idx);
      case (idx)
         0: begin
            chk("w0_byte0",  byte_of(bus.IMGIN, 0),  8'h00);
            chk("w0_byte4",  byte_of(bus.IMGIN, 4),  8'h04);
            chk("w0_byte5",  byte_of(bus.IMGIN, 5),  8'h1C);
            chk("w0_byte24", byte_of(bus.IMGIN, 24), 8'h74);
         end
         2: begin
            chk("w2_y",      bus.Y, 5'd2);
            chk("w2_byte0",  byte_of(bus.IMGIN, 0),  8'h02);
            chk("w2_byte24", byte_of(bus.IMGIN, 24), 8'h76);
         end
         24: begin
            chk("w24_x",     bus.X, 5'd1);
            chk("w24_y",     bus.Y, 5'd0);
            chk("w24_byte0", byte_of(bus.IMGIN, 0),  8'h1C);
         end
         26: begin
            chk("w26_byte0",  byte_of(bus.IMGIN, 0),  8'h1E);
            chk("w26_byte24", byte_of(bus.IMGIN, 24), 8'h92);
         end
         575: begin
            chk("w575_x",      bus.X, 5'd23);
            chk("w575_y",      bus.Y, 5'd23);
            chk("w575_byte0",  byte_of(bus.IMGIN, 0),  8'h9B);
            chk("w575_byte24", byte_of(bus.IMGIN, 24), 8'h0F);
         end
         default: ;
      endcase
   endtask

   // ---------------- monitor ----------------
   int cyc            = 0;
   int last_done_cyc  = -100;
   int start_cnt      = 0;
   int frame_done_cnt = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      win_t e;
      if (bus.START === 1'b1) begin
         start_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got START at X=%0d Y=%0d, required no START", bus.X, bus.Y);
         end else begin
            e = exp_q.pop_front();
            $display("window %0d: X=%0d Y=%0d WIN_CNT=%0d", e.idx, bus.X, bus.Y, bus.WIN_CNT);
            chk("win_x",     bus.X, e.x);
            chk("win_y",     bus.Y, e.y);
            chk("win_imgin", bus.IMGIN, e.img);
            chk("win_cnt",   bus.WIN_CNT, e.idx);
            if (directed) check_directed(e.idx);
         end
      end
      if (bus.FRAME_DONE === 1'b1) begin
         frame_done_cnt++;
         $display("frame done: WIN_CNT=%0d", bus.WIN_CNT);
         chk("fd_win_cnt",    bus.WIN_CNT, NWIN);
         chk("fd_latency",    cyc - last_done_cyc, 2);
         chk("fd_not_start",  bus.START, 1'b0);
         chk("fd_queue_left", exp_q.size(), 0);
      end
      if (bus.DONE === 1'b1) last_done_cyc = cyc;
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_frame();
      int n;
      @(negedge CLK);
      bus.IMG_START = 1'b1;
      @(negedge CLK);          // the posedge in between is the sample edge
      bus.IMG_START = 1'b0;
      n = 1;                   // this is cycle 1 after the sample edge
      while (bus.START !== 1'b1 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk("first_start_cycle", n, 27);
   endtask

   task automatic wait_starts(input int target, input int budget);
      int n = 0;
      while (start_cnt < target && n < budget) begin
         @(negedge CLK);
         #1;
         n++;
      end
      chk("start_timeout", start_cnt >= target, 1'b1);
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n = 0;
      while (frame_done_cnt < target && n < budget) begin
         @(negedge CLK);
         #1;
         n++;
      end
      chk("frame_timeout", frame_done_cnt >= target, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_pix_addr"},   bus.PIX_ADDR, 0);
      chk({tag, "_imgin"},      bus.IMGIN, 0);
      chk({tag, "_x"},          bus.X, 0);
      chk({tag, "_y"},          bus.Y, 0);
      chk({tag, "_start"},      bus.START, 0);
      chk({tag, "_win_cnt"},    bus.WIN_CNT, 0);
      chk({tag, "_busy"},       bus.BUSY, 0);
      chk({tag, "_frame_done"}, bus.FRAME_DONE, 0);
   endtask

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation did not end, required end within 90000 cycles");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int base;
      bus.IMG_START = 1'b0;
      for (int a = 0; a < IMG_W*IMG_W; a++) mem[a] = 8'(a);

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_all_zero("reset");
      nRST = 1'b1;

      // Frame A: identity image, fixed DONE delay, stray IMG_START mid-frame.
      directed = 1'b1;
      push_frame();
      base = start_cnt;
      start_frame();
      wait_starts(base + 11, 2000);     // window 10 has just issued
      @(negedge CLK);                   // now in WAIT of window 10
      bus.IMG_START = 1'b1;
      @(negedge CLK);
      bus.IMG_START = 1'b0;
      wait_frames(1, 30000);
      chk("frameA_start_count", start_cnt - base, NWIN);
      @(negedge CLK);
      chk("frameA_busy_after", bus.BUSY, 1'b0);
      chk("frameA_cnt_hold",   bus.WIN_CNT, NWIN);
      directed = 1'b0;

      // Frame B: DONE held high before the request must not advance.
      core_auto = 1'b0;
      done_man  = 1'b1;
      repeat (3) @(negedge CLK);
      push_frame();
      base = start_cnt;
      start_frame();
      repeat (20) @(negedge CLK);
      chk("held_done_no_start", start_cnt - base, 1);
      chk("held_done_win_cnt",  bus.WIN_CNT, 0);
      chk("held_done_busy",     bus.BUSY, 1'b1);
      @(negedge CLK);
      done_man = 1'b0;
      @(negedge CLK);
      done_man = 1'b1;
      @(negedge CLK);
      done_man  = 1'b0;
      core_auto = 1'b1;
      wait_starts(base + 5, 1000);      // window 4 has just issued
      repeat (15) @(negedge CLK);       // window 5 fetch in progress
      #2;
      nRST = 1'b0;
      #1;
      check_all_zero("async_reset");
      exp_q.delete();
      repeat (3) @(negedge CLK);
      nRST = 1'b1;
      base = start_cnt;
      repeat (60) @(negedge CLK);
      chk("post_reset_no_start", start_cnt - base, 0);
      chk("post_reset_busy",     bus.BUSY, 1'b0);

      // Frame C: random image, random DONE delays.
      for (int a = 0; a < IMG_W*IMG_W; a++) mem[a] = 8'($urandom);
      rand_delay = 1'b1;
      push_frame();
      base = start_cnt;
      start_frame();
      wait_frames(2, 30000);
      chk("frameC_start_count", start_cnt - base, NWIN);
      @(negedge CLK);
      chk("frameC_busy_after", bus.BUSY, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
